bcd_timekeeper: RTL and testbench
=================================

Name: bcd_timekeeper

Overview:
- Upstream time source for the 4-digit seven-segment clock.
- Divides the system clock to a 1 Hz tick and keeps 24-hour HH:MM:SS in packed BCD.
- Digits and a colon-blink flag go to the display scan/segment stage.
- Two user inputs set hours and minutes directly, with no carry between fields.

Parameters:
- TICK_DIV, 10000: system clock cycles per one-second tick; must be ≥ 2.
- CNT_W, 14: prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  1 = prescaler counts; 0 = time frozen, prescaler holds its value.
- set_hr  input  1  level input; each rising edge (sampled) increments hours.
- set_min  input  1  level input; each rising edge (sampled) increments minutes.
- hr_t  output  2  hours tens, BCD 0..2.
- hr_u  output  4  hours units, BCD 0..9.
- min_t  output  3  minutes tens, BCD 0..5.
- min_u  output  4  minutes units, BCD 0..9.
- sec_t  output  3  seconds tens, BCD 0..5.
- sec_u  output  4  seconds units, BCD 0..9.
- sec_tick  output  1  one-cycle pulse on the cycle the seconds field advances.
- colon  output  1  1 for the first half of each second, else 0.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - Prescaler cleared; all BCD fields = 0 (time 00:00:00).
  - sec_tick = 0; colon = 1; edge-detect history registers = 0.
  - Reset asserted mid-count aborts the count immediately; there is no partial tick.
- Prescaler:
  - When run = 1, pcnt increments by 1 each cycle.
  - When pcnt == TICK_DIV-1, pcnt wraps to 0 and an internal tick fires that same cycle.
  - Field updates are registered and appear the cycle after the wrap edge.
  - sec_tick is registered alongside the updated fields.
  - When run = 0, pcnt holds and no tick fires.
- Colon:
  - colon = 1 while pcnt < TICK_DIV/2 (integer divide), else 0.
  - Registered, so it lags pcnt by one cycle.
- Seconds on tick:
  - sec_u increments; at 9 it wraps to 0 and sec_t increments.
  - When sec_t:sec_u = 5:9, both go to 0 and a minute carry is raised.
- Minutes on carry:
  - Same BCD rule; 59 → 00 raises an hour carry.
- Hours on carry:
  - 23 → 00. hr_u wraps 9 → 0 with hr_t incrementing.
  - Legal hours are 00..23 only.
- Set inputs:
  - set_hr and set_min are sampled through a 2-flop synchronizer, then a rising-edge detector.
  - Each detected edge yields exactly one increment, 3 cycles after the input edge.
  - set_min: minutes +1 with 59 → 00, no hour carry; seconds cleared to 00; pcnt cleared to 0.
  - set_hr: hours +1 with 23 → 00; minutes and seconds untouched.
  - Set edges work regardless of run.
- Simultaneous events:
  - set_min edge and tick in the same cycle: set_min wins; the tick is discarded and sec_tick = 0.
  - set_hr edge and a tick-driven hour carry in the same cycle: hours advance by exactly 1 (no double increment).
  - set_hr edge and set_min edge in the same cycle: both apply independently.
- Holding a set input high gives one increment only; there is no auto-repeat.
- Output invariant: outputs never show illegal BCD (hr > 23, tens > 5, units > 9) in any cycle after reset.

Test Plan (TICK_DIV=4, CNT_W=3):
- Reset, run=1 for 12 cycles:
  - sec_tick pulses exactly 3 times, 4 cycles apart.
  - sec_u = 3 afterwards.
  - colon pattern over one second is 1,1,0,0.
- Preload via set pulses to 23:59, then let seconds count to 59 and one more tick:
  - Fields go 23:59:59 → 00:00:00 on a single update.
  - sec_tick = 1 on that cycle.
- set_min held high for 20 cycles:
  - Minutes increment exactly once, 3 cycles after the rising edge.
  - Seconds = 00, hours unchanged.
- set_min edge aligned so its detected edge coincides with the prescaler wrap:
  - Minutes +1, seconds = 00.
  - No sec_tick pulse that cycle.
  - The next tick follows TICK_DIV cycles later.
- run=0 for 50 cycles mid-second, then run=1:
  - No field changes and no sec_tick while frozen.
  - The next tick arrives after the remaining count only, with no reset of pcnt.
- Assert rst_n low asynchronously between clock edges at 12:34:56:
  - All outputs read 00:00:00 before the next clk edge.
  - Counting resumes normally after release.

Source files
------------

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: divides clk to a one-second tick and keeps 24-hour HH:MM:SS in packed BCD.
// Latency: fields and sec_tick update the cycle after the prescaler wrap; set inputs apply 3 cycles after their edge.
// Backpressure: none; run=0 freezes the prescaler, set edges are always accepted.

module bcd_timekeeper #(
  parameter int TICK_DIV = 10000,
  parameter int CNT_W    = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_hr,
  input  logic       set_min,
  output logic [1:0] hr_t,
  output logic [3:0] hr_u,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       sec_tick,
  output logic       colon
);

  // Prescaler terminal count and the colon threshold, sized to the counter.
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] COLON_HALF = CNT_W'(TICK_DIV / 2);

  // Prescaler and colon state.
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             colon_q, colon_d;
  logic             sec_tick_q, sec_tick_d;

  // Two-flop synchronizers plus one history flop per set input.
  logic hr_s1_q, hr_s1_d;
  logic hr_s2_q, hr_s2_d;
  logic hr_hist_q, hr_hist_d;
  logic min_s1_q, min_s1_d;
  logic min_s2_q, min_s2_d;
  logic min_hist_q, min_hist_d;

  // Time-of-day fields, packed BCD.
  logic [1:0] hr_t_q, hr_t_d;
  logic [3:0] hr_u_q, hr_u_d;
  logic [2:0] min_t_q, min_t_d;
  logic [3:0] min_u_q, min_u_d;
  logic [2:0] sec_t_q, sec_t_d;
  logic [3:0] sec_u_q, sec_u_d;

  // Decoded events for the current cycle.
  logic tick;
  logic hr_edge;
  logic min_edge;
  logic sec_adv;
  logic min_carry;
  logic hr_carry;
  logic min_bump;
  logic hr_bump;

  // Modulo-60 BCD increment on a {tens, units} pair: 59 wraps to 00.
  function automatic logic [6:0] bcd60_inc(input logic [2:0] t, input logic [3:0] u);
    logic [2:0] nt;
    logic [3:0] nu;
    nt = t;
    nu = u + 4'd1;
    if (u == 4'd9) begin
      nu = 4'd0;
      nt = (t == 3'd5) ? 3'd0 : t + 3'd1;
    end
    return {nt, nu};
  endfunction

  // Modulo-24 BCD increment on hours: 23 wraps to 00, x9 carries into tens.
  function automatic logic [5:0] hr24_inc(input logic [1:0] t, input logic [3:0] u);
    logic [1:0] nt;
    logic [3:0] nu;
    nt = t;
    nu = u + 4'd1;
    if (t == 2'd2 && u == 4'd3) begin
      nt = 2'd0;
      nu = 4'd0;
    end else if (u == 4'd9) begin
      nt = t + 2'd1;
      nu = 4'd0;
    end
    return {nt, nu};
  endfunction

  // Shift set inputs through the synchronizer and edge-history chain.
  always_comb begin
    hr_s1_d    = set_hr;
    hr_s2_d    = hr_s1_q;
    hr_hist_d  = hr_s2_q;
    min_s1_d   = set_min;
    min_s2_d   = min_s1_q;
    min_hist_d = min_s2_q;
  end

  // Decode this cycle's events; a set_min edge discards a coincident tick.
  always_comb begin
    hr_edge   = hr_s2_q & ~hr_hist_q;
    min_edge  = min_s2_q & ~min_hist_q;
    tick      = run & (pcnt_q == TICK_LAST);
    sec_adv   = tick & ~min_edge;
    min_carry = sec_adv & (sec_t_q == 3'd5) & (sec_u_q == 4'd9);
    hr_carry  = min_carry & (min_t_q == 3'd5) & (min_u_q == 4'd9);
    min_bump  = min_edge | min_carry;
    // A set edge and a rollover carry in the same cycle still advance hours once.
    hr_bump   = hr_edge | hr_carry;
  end

  // Prescaler: count while running, wrap on the tick, restart on a minute set.
  always_comb begin
    pcnt_d  = pcnt_q;
    colon_d = (pcnt_q < COLON_HALF);
    if (min_edge) begin
      pcnt_d = '0;
    end else if (run) begin
      if (tick) begin
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + CNT_W'(1);
      end
    end
  end

  // Field next-state: seconds, then minutes, then hours, each with its own trigger.
  always_comb begin
    sec_t_d    = sec_t_q;
    sec_u_d    = sec_u_q;
    min_t_d    = min_t_q;
    min_u_d    = min_u_q;
    hr_t_d     = hr_t_q;
    hr_u_d     = hr_u_q;
    sec_tick_d = sec_adv;

    if (min_edge) begin
      sec_t_d = 3'd0;
      sec_u_d = 4'd0;
    end else if (sec_adv) begin
      {sec_t_d, sec_u_d} = bcd60_inc(sec_t_q, sec_u_q);
    end

    // Minute set wraps 59 to 00 without touching hours; only a tick carry reaches hours.
    if (min_bump) begin
      {min_t_d, min_u_d} = bcd60_inc(min_t_q, min_u_q);
    end

    if (hr_bump) begin
      {hr_t_d, hr_u_d} = hr24_inc(hr_t_q, hr_u_q);
    end
  end

  // State registers; reset aborts any partial count and shows 00:00:00 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      colon_q    <= 1'b1;
      sec_tick_q <= 1'b0;
      hr_s1_q    <= 1'b0;
      hr_s2_q    <= 1'b0;
      hr_hist_q  <= 1'b0;
      min_s1_q   <= 1'b0;
      min_s2_q   <= 1'b0;
      min_hist_q <= 1'b0;
      hr_t_q     <= 2'd0;
      hr_u_q     <= 4'd0;
      min_t_q    <= 3'd0;
      min_u_q    <= 4'd0;
      sec_t_q    <= 3'd0;
      sec_u_q    <= 4'd0;
    end else begin
      pcnt_q     <= pcnt_d;
      colon_q    <= colon_d;
      sec_tick_q <= sec_tick_d;
      hr_s1_q    <= hr_s1_d;
      hr_s2_q    <= hr_s2_d;
      hr_hist_q  <= hr_hist_d;
      min_s1_q   <= min_s1_d;
      min_s2_q   <= min_s2_d;
      min_hist_q <= min_hist_d;
      hr_t_q     <= hr_t_d;
      hr_u_q     <= hr_u_d;
      min_t_q    <= min_t_d;
      min_u_q    <= min_u_d;
      sec_t_q    <= sec_t_d;
      sec_u_q    <= sec_u_d;
    end
  end

  assign hr_t     = hr_t_q;
  assign hr_u     = hr_u_q;
  assign min_t    = min_t_q;
  assign min_u    = min_u_q;
  assign sec_t    = sec_t_q;
  assign sec_u    = sec_u_q;
  assign sec_tick = sec_tick_q;
  assign colon    = colon_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper: directed table, corner sequences and random run against a time-of-day model.
// Latency: checks sample on the falling edge after each rising edge.
// Backpressure: not applicable; all phases run a fixed number of cycles.

module tb_bcd_timekeeper;

  localparam int D = 4;
  localparam int W = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       set_hr;
  logic       set_min;
  logic [1:0] hr_t;
  logic [3:0] hr_u;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic       sec_tick;
  logic       colon;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_timekeeper #(.TICK_DIV(D), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .set_hr(set_hr), .set_min(set_min),
    .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
    .sec_t(sec_t), .sec_u(sec_u), .sec_tick(sec_tick), .colon(colon)
  );

  // Reference model: time kept as plain integers, set inputs as a sample history.
  int  mh, mm, ms, mpc, mtick, mcolon;
  int  tot, nh;
  bit  dh, dm, tk;
  bit  hhist [3];
  bit  mhist [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh = 0; mm = 0; ms = 0; mpc = 0; mtick = 0; mcolon = 1;
      for (int i = 0; i < 3; i++) begin
        hhist[i] = 1'b0;
        mhist[i] = 1'b0;
      end
    end else begin
      // An input level counts once it has been seen two edges ago but not three.
      dh = hhist[1] && !hhist[2];
      dm = mhist[1] && !mhist[2];
      hhist[2] = hhist[1]; hhist[1] = hhist[0]; hhist[0] = set_hr;
      mhist[2] = mhist[1]; mhist[1] = mhist[0]; mhist[0] = set_min;
      tk     = run && (mpc == D - 1);
      mcolon = (mpc < D / 2) ? 1 : 0;
      mtick  = 0;
      if (dm) begin
        mm  = (mm + 1) % 60;
        ms  = 0;
        mpc = 0;
        if (dh) mh = (mh + 1) % 24;
      end else begin
        if (run) mpc = (mpc + 1) % D;
        if (tk) begin
          tot = (mh * 3600 + mm * 60 + ms + 1) % 86400;
          nh  = tot / 3600;
          mm  = (tot / 60) % 60;
          ms  = tot % 60;
          if (dh && nh == mh) nh = (mh + 1) % 24;
          mh    = nh;
          mtick = 1;
        end else if (dh) begin
          mh = (mh + 1) % 24;
        end
      end
    end
  end

  function automatic int dut_time();
    return (int'(hr_t) * 10 + int'(hr_u)) * 10000 + (int'(min_t) * 10 + int'(min_u)) * 100
           + int'(sec_t) * 10 + int'(sec_u);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    run = 1'b0; set_hr = 1'b0; set_min = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input bit hr);
    if (hr) set_hr = 1'b1; else set_min = 1'b1;
    cyc(2);
    set_hr = 1'b0; set_min = 1'b0;
    cyc(2);
  endtask

  typedef struct {
    bit run;
    bit shr;
    bit smin;
    int n;
    int exp_time;
    bit exp_tick;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int nt, last, first;

    tbl[0]  = '{1'b1, 1'b0, 1'b0,  2,     3, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 50,     3, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0,  1,     3, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0,  1,     4, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1,  2,     4, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1,  1,   100, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 20,   100, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0,  5,   100, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0,  3, 10100, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1,  3, 10200, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0,  4, 10201, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1,  3, 20300, 1'b0};

    rst_n = 1'b0; run = 1'b0; set_hr = 1'b0; set_min = 1'b0;
    cyc(2);
    chk("reset_time", dut_time(), 0);
    chk("reset_tick", int'(sec_tick), 0);
    chk("reset_colon", int'(colon), 1);

    // First seconds after reset: tick count, spacing and colon pattern.
    rst_n = 1'b1; run = 1'b1;
    nt = 0; last = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk("colon_pattern", int'(colon), (k % 4 == 1 || k % 4 == 2) ? 1 : 0);
      if (sec_tick) begin
        nt++;
        if (last > 0) chk("tick_spacing", k - last, D);
        else first = k;
        last = k;
      end
    end
    chk("tick_count", nt, 3);
    chk("first_tick_cycle", first, D);
    chk("sec_u_after_12", int'(sec_u), 3);

    // Directed table: freeze/resume, set holds, simultaneous sets.
    for (int i = 0; i < 12; i++) begin
      run = tbl[i].run; set_hr = tbl[i].shr; set_min = tbl[i].smin;
      cyc(tbl[i].n);
      chk($sformatf("tbl%0d_time", i), dut_time(), tbl[i].exp_time);
      chk($sformatf("tbl%0d_tick", i), int'(sec_tick), int'(tbl[i].exp_tick));
    end

    // Day rollover: preload 23:59, count to 23:59:59, then one more tick.
    do_reset();
    for (int i = 0; i < 23; i++) pulse(1'b1);
    for (int i = 0; i < 59; i++) pulse(1'b0);
    chk("preload_2359", dut_time(), 235900);
    run = 1'b1;
    cyc(59 * D);
    chk("at_235959", dut_time(), 235959);
    cyc(D - 1);
    chk("hold_235959", dut_time(), 235959);
    chk("hold_tick", int'(sec_tick), 0);
    cyc(1);
    chk("rollover_time", dut_time(), 0);
    chk("rollover_tick", int'(sec_tick), 1);

    // Minute set landing on the prescaler wrap discards the tick.
    cyc(1);
    set_min = 1'b1;
    cyc(3);
    chk("setmin_wrap_time", dut_time(), 100);
    chk("setmin_wrap_tick", int'(sec_tick), 0);
    set_min = 1'b0;
    cyc(D - 1);
    chk("after_wrap_no_tick", int'(sec_tick), 0);
    chk("after_wrap_time", dut_time(), 100);
    cyc(1);
    chk("next_tick_time", dut_time(), 101);
    chk("next_tick_pulse", int'(sec_tick), 1);

    // Asynchronous reset between edges at 12:34:56.
    do_reset();
    for (int i = 0; i < 12; i++) pulse(1'b1);
    for (int i = 0; i < 34; i++) pulse(1'b0);
    run = 1'b1;
    cyc(56 * D);
    chk("at_123456", dut_time(), 123456);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_time", dut_time(), 0);
    chk("async_rst_tick", int'(sec_tick), 0);
    chk("async_rst_colon", int'(colon), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(D);
    chk("post_rst_time", dut_time(), 1);
    chk("post_rst_tick", int'(sec_tick), 1);

    // Random stimulus against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) set_hr = ~set_hr;
      if ($urandom_range(0, 5) == 0) set_min = ~set_min;
      cyc(1);
      chk("rand_time", dut_time(), mh * 10000 + mm * 100 + ms);
      chk("rand_flags", int'({sec_tick, colon}), mtick * 2 + mcolon);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
